ahb_master_bridge: RTL
======================

AHB_MASTER_BRIDGE -- requirements
Module: ahb_master_bridge

Interface
REQ-001 SHALL have parameter: WAIT_CNT_W, 8, width of the saturating wait-state counter output.
REQ-002 SHALL have port: HCLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: cpu_req  input  1  one-cycle transfer request pulse from the core.
REQ-005 SHALL have port: cpu_we  input  1  1 = write, 0 = read; qualified by cpu_req.
REQ-006 SHALL have port: cpu_addr  input  32  byte address; qualified by cpu_req.
REQ-007 SHALL have port: cpu_wdata  input  32  write data; qualified by cpu_req.
REQ-008 SHALL have port: cpu_rdata  output  32  read data; valid while cpu_ack=1.
REQ-009 SHALL have port: cpu_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: cpu_err  output  1  error flag; valid while cpu_ack=1.
REQ-011 SHALL have port: HADDR  output  32  AHB-Lite address.
REQ-012 SHALL have port: HWRITE  output  1  AHB-Lite direction.
REQ-013 SHALL have port: HTRANS  output  2  AHB-Lite transfer type (IDLE=2'b00, NONSEQ=2'b10 only).
REQ-014 SHALL have port: HWDATA  output  32  AHB-Lite write data.
REQ-015 SHALL have port: HRDATA  input  32  interconnect read data.
REQ-016 SHALL have port: HREADY  input  1  interconnect ready.
REQ-017 SHALL have port: HRESP  input  1  interconnect response, 1 = ERROR.
REQ-018 SHALL have port: wait_cycles  output  WAIT_CNT_W  HREADY-low cycles seen in last transfer (address + data phase), saturating at all-ones.

Function
REQ-019 SHALL implement FSM states IDLE, ADDR, DATA, ERRDONE; all outputs registered.
REQ-020 IDLE: cpu_req=1, cpu_ack=0, cpu_addr[1:0]=0 -> latch addr/we/wdata, drive HADDR/HWRITE, HTRANS<=NONSEQ, clear wait counter, go ADDR.
REQ-021 IDLE: cpu_req=1, cpu_ack=0, cpu_addr[1:0]!=0 -> no bus transfer, go ERRDONE; next cycle cpu_ack=1, cpu_err=1, return IDLE.
REQ-022 cpu_req SHALL be ignored in ADDR, DATA, ERRDONE, and in any IDLE cycle where cpu_ack=1.
REQ-023 ADDR: HTRANS=NONSEQ, HADDR/HWRITE stable; HREADY=1 at edge -> HTRANS<=IDLE, go DATA; HREADY=0 -> stay, increment counter.
REQ-024 DATA: HWDATA = latched wdata (writes; reads drive latched value too); HADDR/HWRITE held.
REQ-025 DATA, HREADY=0 -> stay, increment counter; HRESP ignored while HREADY=0.
REQ-026 DATA, HREADY=1 at edge -> cpu_ack<=1 for exactly one cycle, cpu_err<=HRESP, cpu_rdata<=HRDATA on reads (unchanged on writes), go IDLE.
REQ-027 Zero-wait-state latency: req sampled at edge N -> ADDR N+1 -> DATA N+2 -> cpu_ack high in cycle after edge N+3 (3 cycles).
REQ-028 Only one outstanding transfer; no pipelined NONSEQ during DATA; HTRANS SHALL never be BUSY or SEQ.
REQ-029 wait counter SHALL saturate at 2^WAIT_CNT_W-1, never wrap; wait_cycles updates at completion only.
REQ-030 HRESP during ADDR or IDLE SHALL be ignored (interconnect default slave drives HRESP=1 when idle).

Reset
REQ-031 HRESETn low SHALL asynchronously force: state IDLE, HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, cpu_rdata=0, cpu_ack=0, cpu_err=0, wait_cycles=0.
REQ-032 Reset mid-transfer SHALL abandon it with no cpu_ack; first request after release SHALL start cleanly from IDLE.

Verification
REQ-033 Read 0x0000_0010, HREADY=1 always, HRDATA=0xDEADBEEF in DATA -> HTRANS=10 one cycle, cpu_ack 3 cycles after req, cpu_rdata=0xDEADBEEF, cpu_err=0, wait_cycles=0.
REQ-034 Write 0x0000_7F00 data 0x0000_00A5, HREADY low 3 cycles in DATA -> HWDATA=0xA5 throughout DATA, cpu_ack 6 cycles after req, wait_cycles=3.
REQ-035 Read with HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> cpu_ack=1, cpu_err=1, single pulse.
REQ-036 Request to 0x0000_0002 -> HTRANS stays 00, cpu_ack=1 and cpu_err=1 two cycles after req.
REQ-037 HREADY held low 300 cycles with WAIT_CNT_W=8 -> wait_cycles=255; second cpu_req during busy and during ack cycle -> ignored, exactly one transfer.
REQ-038 HRESETn pulsed low in DATA -> all outputs zero immediately, no cpu_ack; next read completes normally.

Source files
------------

// File: rtl/ahb_master_bridge.sv
// Single-outstanding AHB-Lite master: turns one-cycle CPU requests into NONSEQ transfers.
// Latency 3 cycles req->ack with zero wait states; HREADY stalls extend ADDR/DATA; requests are dropped while busy.
module ahb_master_bridge #(
    parameter int WAIT_CNT_W = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic [31:0]           HADDR,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic [WAIT_CNT_W-1:0] wait_cycles
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_DATA    = 2'd2,
        S_ERRDONE = 2'd3
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [31:0]           haddr_q, haddr_d;
    logic                  hwrite_q, hwrite_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [31:0]           hwdata_q, hwdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [WAIT_CNT_W-1:0] wcnt_q, wcnt_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic [WAIT_CNT_W-1:0] wcnt_sat;

    // Counter sticks at all-ones instead of wrapping on very long stalls.
    assign wcnt_sat = (wcnt_q == {WAIT_CNT_W{1'b1}}) ? wcnt_q : wcnt_q + CNT_ONE;

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        htrans_d = htrans_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        err_d    = err_q;
        wcnt_d   = wcnt_q;
        wait_d   = wait_q;
        case (state_q)
            S_IDLE: begin
                // The ack cycle is still IDLE; a request there is dropped.
                if (cpu_req && !ack_q) begin
                    if (cpu_addr[1:0] == 2'b00) begin
                        haddr_d  = cpu_addr;
                        hwrite_d = cpu_we;
                        hwdata_d = cpu_wdata;
                        htrans_d = TR_NONSEQ;
                        wcnt_d   = '0;
                        state_d  = S_ADDR;
                    end else begin
                        state_d = S_ERRDONE;
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    htrans_d = TR_IDLE;
                    state_d  = S_DATA;
                end else begin
                    wcnt_d = wcnt_sat;
                end
            end
            S_DATA: begin
                // HRESP only means something when HREADY completes the data phase.
                if (HREADY) begin
                    ack_d   = 1'b1;
                    err_d   = HRESP;
                    wait_d  = wcnt_q;
                    state_d = S_IDLE;
                    if (!hwrite_q) begin
                        rdata_d = HRDATA;
                    end
                end else begin
                    wcnt_d = wcnt_sat;
                end
            end
            S_ERRDONE: begin
                ack_d   = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            htrans_q <= TR_IDLE;
            hwdata_q <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            wcnt_q   <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            htrans_q <= htrans_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            wcnt_q   <= wcnt_d;
            wait_q   <= wait_d;
        end
    end

    assign cpu_rdata   = rdata_q;
    assign cpu_ack     = ack_q;
    assign cpu_err     = err_q;
    assign HADDR       = haddr_q;
    assign HWRITE      = hwrite_q;
    assign HTRANS      = htrans_q;
    assign HWDATA      = hwdata_q;
    assign wait_cycles = wait_q;

endmodule
